// File: rtl/fir_output_quantizer.sv
// fir_output_quantizer
//   Output stage of the FIR filter. Each full-precision FIR result is captured
//   on its one-cycle valid pulse, rounded half-up, arithmetically shifted right
//   by SHIFT and saturated to a signed OUT_WIDTH value. Quantized samples are
//   queued in a DEPTH-entry FIFO drained through a valid/ready port.
//
//   Handshake: a sample transfers on every rising clk edge where
//   out_valid && out_ready. out_valid means the FIFO is not empty, and
//   out_data holds stable while out_valid=1 and out_ready=0. There is no
//   backpressure toward the FIR. A result that arrives while the FIFO is full
//   (and nothing is popped that cycle) is dropped and flagged.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   fir_result in   IN_WIDTH two's complement FIR result
//   fir_valid  in   one-cycle pulse, fir_result valid
//   out_data   out  head-of-FIFO quantized sample (0 when empty)
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer accepts out_data
//   level      out  FIFO occupancy 0..DEPTH
//   sat_flag   out  sticky: a clipped sample was written to the FIFO
//   overflow   out  sticky: a result was dropped on a full FIFO
//   clr_flags  in   synchronous clear of both sticky flags (set wins)
module fir_output_quantizer #(
    parameter int WIDTH     = 16,
    parameter int LENGHT    = 100,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15,
    parameter int DEPTH     = 4,
    localparam int IN_WIDTH = $clog2(LENGHT) + 2 * WIDTH,
    localparam int PW       = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  fir_result,
    input  logic                 fir_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PW-1:0]        level,
    output logic                 sat_flag,
    output logic                 overflow,
    input  logic                 clr_flags
);

    localparam int AW = PW - 1;

    // Rounding constant 2^(SHIFT-1); the shift-then-halve form gives 0 for SHIFT=0.
    localparam logic signed [IN_WIDTH:0] RND_ONE = (IN_WIDTH + 1)'(1);
    localparam logic signed [IN_WIDTH:0] RND     = (RND_ONE <<< SHIFT) >>> 1;

    // Saturation bounds expressed at the extended working width.
    localparam logic signed [IN_WIDTH:0] Q_MAX =
        {{(IN_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] Q_MIN =
        {{(IN_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    // ---------------- Stage 1: round, shift, saturate ----------------
    logic signed [IN_WIDTH:0] sum;
    logic signed [IN_WIDTH:0] q;
    logic [OUT_WIDTH-1:0]     q_data;
    logic                     q_sat;

    always_comb begin
        // One extra bit keeps the rounding add from wrapping at the positive limit.
        sum    = $signed({fir_result[IN_WIDTH-1], fir_result}) + RND;
        q      = sum >>> SHIFT;
        q_data = q[OUT_WIDTH-1:0];
        q_sat  = 1'b0;
        if (q > Q_MAX) begin
            q_data = Q_MAX[OUT_WIDTH-1:0];
            q_sat  = 1'b1;
        end else if (q < Q_MIN) begin
            q_data = Q_MIN[OUT_WIDTH-1:0];
            q_sat  = 1'b1;
        end
    end

    logic                 s1_valid;
    logic [OUT_WIDTH-1:0] s1_data;
    logic                 s1_sat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_sat   <= 1'b0;
        end else begin
            s1_valid <= fir_valid;
            if (fir_valid) begin
                s1_data <= q_data;
                s1_sat  <= q_sat;
            end
        end
    end

    // ---------------- Stage 2: FIFO ----------------
    logic [OUT_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 push;
    logic                 drop;

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop   = !empty && out_ready;
        // A pop frees the slot in the same cycle, so a full FIFO still accepts.
        push  = s1_valid && (!full || pop);
        drop  = s1_valid && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s1_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sat_flag <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Set events take priority over the clear.
            if (push && s1_sat) begin
                sat_flag <= 1'b1;
            end else if (clr_flags) begin
                sat_flag <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        out_valid = !empty;
        out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
        level     = wr_ptr - rd_ptr;
    end

endmodule

// File: tb/tb_fir_output_quantizer.sv
module tb_fir_output_quantizer;

    localparam int IW = 39;
    localparam int OW = 16;
    localparam int LW = 3;

    logic          clk;
    logic          rst;
    logic [IW-1:0] fir_result;
    logic          fir_valid;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          sat_flag;
    logic          overflow;
    logic          clr_flags;

    int total;
    int bad;

    logic [OW-1:0] exp_q[$];

    fir_output_quantizer dut (
        .clk        (clk),
        .rst        (rst),
        .fir_result (fir_result),
        .fir_valid  (fir_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .sat_flag   (sat_flag),
        .overflow   (overflow),
        .clr_flags  (clr_flags)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver / checker tasks ----------------
    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_val(input logic [IW-1:0] v);
        fir_result = v;
        fir_valid  = 1'b1;
        tick();
        fir_valid  = 1'b0;
    endtask

    // Check the head sample against the scoreboard, then pop it.
    task automatic pop_check(input string tag);
        logic [OW-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: got=%0h exp=<scoreboard empty>", tag, out_data);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 64'(out_valid), 64'd1);
            check(tag, 64'(out_data), 64'(e));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [IW-1:0] v_pos_big;
        logic [IW-1:0] v_neg_big;
        total      = 0;
        bad        = 0;
        rst        = 1'b0;
        fir_result = '0;
        fir_valid  = 1'b0;
        out_ready  = 1'b0;
        clr_flags  = 1'b0;
        v_pos_big  = 39'sd2147483648;       // 2^31
        v_neg_big  = -39'sd2148532224;      // -2^31 - 2^20

        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        check("rst_level", 64'(level),     64'd0);
        check("rst_sat",   64'(sat_flag),  64'd0);
        check("rst_ovf",   64'(overflow),  64'd0);
        #3 rst = 1'b1;
        tick();

        // 1 rounding
        push_val(39'sd16384);   exp_q.push_back(16'h0001);
        push_val(39'sd16383);   exp_q.push_back(16'h0000);
        push_val(-39'sd16384);  exp_q.push_back(16'h0000);
        push_val(-39'sd16385);  exp_q.push_back(16'hFFFF);
        tick();
        check("rnd_level", 64'(level), 64'd4);
        check("rnd_sat", 64'(sat_flag), 64'd0);
        repeat (4) pop_check("rnd_data");
        check("rnd_empty", 64'(out_valid), 64'd0);

        // 2 saturation and flag clear
        push_val(v_pos_big);    exp_q.push_back(16'h7FFF);
        push_val(v_neg_big);    exp_q.push_back(16'h8000);
        tick();
        check("sat_set", 64'(sat_flag), 64'd1);
        check("sat_ovf", 64'(overflow), 64'd0);
        repeat (2) pop_check("sat_data");
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("sat_clr", 64'(sat_flag), 64'd0);
        // Clear coincident with a clipped write: the set wins.
        push_val(v_pos_big);    exp_q.push_back(16'h7FFF);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("sat_set_wins", 64'(sat_flag), 64'd1);
        pop_check("sat_data2");
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("sat_clr2", 64'(sat_flag), 64'd0);

        // 3 latency with out_ready held high
        out_ready  = 1'b1;
        fir_result = 39'sd98304;         // 3 * 32768
        fir_valid  = 1'b1;
        tick();
        fir_valid  = 1'b0;
        check("lat_n_valid", 64'(out_valid), 64'd0);
        check("lat_n_level", 64'(level), 64'd0);
        tick();
        check("lat_n1_valid", 64'(out_valid), 64'd1);
        check("lat_n1_level", 64'(level), 64'd1);
        check("lat_n1_data", 64'(out_data), 64'd3);
        tick();
        check("lat_n2_valid", 64'(out_valid), 64'd0);
        check("lat_n2_level", 64'(level), 64'd0);
        out_ready  = 1'b0;

        // 4 full / overflow
        for (int k = 1; k <= 5; k++) begin
            push_val(IW'(k * 32768));
            if (k <= 4) exp_q.push_back(OW'(k));
        end
        tick();
        check("ovf_level", 64'(level), 64'd4);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_sat", 64'(sat_flag), 64'd0);
        tick();
        check("ovf_hold", 64'(out_data), 64'd1);
        repeat (4) pop_check("ovf_data");
        check("ovf_empty", 64'(out_valid), 64'd0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("ovf_clr", 64'(overflow), 64'd0);

        // 5 simultaneous push and pop while full
        for (int k = 10; k <= 13; k++) begin
            push_val(IW'(k * 32768));
            exp_q.push_back(OW'(k));
        end
        fir_result = IW'(20 * 32768);
        fir_valid  = 1'b1;
        tick();                          // last fill write and s1 primed with 20
        check("pp_start_level", 64'(level), 64'd4);
        for (int k = 21; k <= 29; k++) begin
            exp_q.push_back(OW'(k - 1));
            check("pp_data", 64'(out_data), 64'(exp_q.pop_front()));
            fir_result = IW'(k * 32768);
            fir_valid  = (k <= 28);
            out_ready  = 1'b1;
            tick();
            check("pp_level", 64'(level), 64'd4);
            check("pp_ovf", 64'(overflow), 64'd0);
        end
        fir_valid = 1'b0;
        out_ready = 1'b0;
        repeat (4) pop_check("pp_tail");
        check("pp_empty", 64'(level), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop_empty_level", 64'(level), 64'd0);
        check("pop_empty_valid", 64'(out_valid), 64'd0);

        // 6 asynchronous reset mid-stream
        push_val(v_pos_big);
        push_val(IW'(32768));
        push_val(IW'(65536));
        tick();
        check("rst6_level_pre", 64'(level), 64'd3);
        check("rst6_sat_pre", 64'(sat_flag), 64'd1);
        #3 rst = 1'b0;
        #1;
        check("rst6_valid", 64'(out_valid), 64'd0);
        check("rst6_level", 64'(level), 64'd0);
        check("rst6_data", 64'(out_data), 64'd0);
        check("rst6_sat", 64'(sat_flag), 64'd0);
        check("rst6_ovf", 64'(overflow), 64'd0);
        tick();
        #2 rst = 1'b1;
        tick();
        push_val(IW'(7 * 32768));
        exp_q.push_back(16'd7);
        tick();
        check("rst6_resume_level", 64'(level), 64'd1);
        check("rst6_resume_sat", 64'(sat_flag), 64'd0);
        pop_check("rst6_resume_data");
        check("rst6_resume_empty", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
